// File: rtl/alu_4bit_pkg.sv
// alu_4bit_pkg: opcodes and width constants shared by the ALU top and its core
package alu_4bit_pkg;
    localparam int DATA_W = 4;
    localparam int RES_W  = 5;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_RSV = 3'd7;
endpackage

// File: rtl/alu_4bit_core.sv
// alu_4bit_core: combinational operation decode producing the next result and zero flag
//   a, b        : 4-bit unsigned operands (b unused by shifts)
//   op_code     : 3-bit operation select
//   next_result : 5-bit result, operands zero-extended, wraps modulo 32
//   next_zero   : high when next_result is zero
module alu_4bit_core
    import alu_4bit_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op_code,
    output logic [RES_W-1:0]  next_result,
    output logic              next_zero
);
    logic [RES_W-1:0] ax;
    logic [RES_W-1:0] bx;
    assign ax = {1'b0, a};
    assign bx = {1'b0, b};
    always_comb begin
        case (op_code)
            OP_ADD:  next_result = ax + bx;
            OP_SUB:  next_result = ax - bx;
            OP_AND:  next_result = ax & bx;
            OP_OR:   next_result = ax | bx;
            OP_XOR:  next_result = ax ^ bx;
            OP_SHL:  next_result = {a, 1'b0};
            OP_SHR:  next_result = {2'b0, a[DATA_W-1:1]};
            default: next_result = '0;
        endcase
    end
    assign next_zero = (next_result == '0);
endmodule

// File: rtl/alu_4bit.sv
// alu_4bit: registered 4-bit ALU with 5-bit result and zero flag, one-cycle latency
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset, clears result and sets zero_flag
//   a, b      : 4-bit unsigned operands
//   op_code   : 3-bit operation select
//   result    : registered 5-bit result
//   zero_flag : registered, high exactly when result is zero
module alu_4bit
    import alu_4bit_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op_code,
    output logic [RES_W-1:0]  result,
    output logic              zero_flag
);
    logic [RES_W-1:0] next_result;
    logic             next_zero;
    logic [RES_W-1:0] result_d;
    logic [RES_W-1:0] result_q;
    logic             zero_flag_d;
    logic             zero_flag_q;

    alu_4bit_core u_core (
        .a           (a),
        .b           (b),
        .op_code     (op_code),
        .next_result (next_result),
        .next_zero   (next_zero)
    );

    always_comb begin
        result_d    = rst_n ? next_result : '0;
        zero_flag_d = rst_n ? next_zero : 1'b1;
    end

    always_ff @(posedge clk) begin
        result_q    <= result_d;
        zero_flag_q <= zero_flag_d;
    end

    assign result    = result_q;
    assign zero_flag = zero_flag_q;
endmodule

// File: tb/tb_alu_4bit.sv
// tb_alu_4bit: directed and randomized checks of alu_4bit against an arithmetic reference model
module tb_alu_4bit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic [2:0] op_code = '0;
    logic [4:0] result;
    logic       zero_flag;

    int         checks = 0;
    int         errors = 0;
    bit         have_exp = 1'b0;
    logic [4:0] exp_r = '0;

    alu_4bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .op_code   (op_code),
        .result    (result),
        .zero_flag (zero_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] model(input int x, input int y, input int op);
        int r;
        case (op)
            0:       r = x + y;
            1:       r = x - y + 32;
            2:       r = x & y;
            3:       r = x | y;
            4:       r = x ^ y;
            5:       r = x * 2;
            6:       r = x / 2;
            default: r = 0;
        endcase
        return 5'(r % 32);
    endfunction

    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int av, input int bv, input int opv, input bit rst);
        string tag;
        @(negedge clk);
        if (have_exp) chk("hold", result, exp_r);
        a       = 4'(av);
        b       = 4'(bv);
        op_code = 3'(opv);
        rst_n   = !rst;
        exp_r   = rst ? 5'd0 : model(av, bv, opv);
        @(posedge clk);
        #1;
        tag = $sformatf("op%0d a%0d b%0d rst%0d", opv, av, bv, rst);
        chk({tag, " result"}, result, exp_r);
        chk({tag, " zero"}, {4'b0, zero_flag}, {4'b0, exp_r == 5'd0});
        have_exp = 1'b1;
    endtask

    initial begin
        step(5, 3, 0, 1);
        step(5, 3, 0, 1);
        chk("reset value", result, 5'd0);
        step(5, 3, 0, 0);
        chk("first after reset", result, 5'd8);
        step(3, 2, 0, 0);
        step(15, 1, 0, 0);
        chk("add carry", result, 5'd16);
        step(0, 0, 0, 0);
        step(7, 2, 1, 0);
        step(2, 2, 1, 0);
        step(2, 7, 1, 0);
        chk("sub borrow", result, 5'd27);
        step(12, 10, 2, 0);
        chk("and", result, 5'd8);
        step(12, 3, 3, 0);
        chk("or", result, 5'd15);
        step(10, 3, 4, 0);
        chk("xor", result, 5'd9);
        step(5, 5, 4, 0);
        chk("xor zero", {4'b0, zero_flag}, 5'd1);
        step(5, 0, 5, 0);
        chk("shl 5", result, 5'd10);
        step(5, 15, 5, 0);
        chk("shl 5 b varied", result, 5'd10);
        step(8, 9, 5, 0);
        chk("shl 8", result, 5'd16);
        step(8, 3, 6, 0);
        chk("shr 8", result, 5'd4);
        step(8, 12, 6, 0);
        chk("shr 8 b varied", result, 5'd4);
        step(1, 6, 6, 0);
        chk("shr 1 zero", {4'b0, zero_flag}, 5'd1);
        for (int i = 0; i < 8; i++) step(9, 6, i, 0);
        chk("reserved", result, 5'd0);
        step(9, 6, 0, 0);
        step(9, 6, 1, 1);
        chk("mid reset", result, 5'd0);
        step(9, 6, 2, 0);
        for (int i = 0; i < 300; i++)
            step(int'($urandom_range(15)), int'($urandom_range(15)),
                 int'($urandom_range(7)), ($urandom_range(15) == 0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_4bit.md
# alu_4bit

Registered 4-bit arithmetic/logic unit with a 5-bit result and a zero flag. It takes two 4-bit operands and a 3-bit opcode, computes one of seven operations, and registers the result and flag on the rising clock edge. It serves as a small datapath execution stage, fed by a register file or sequencer and read by downstream logic one cycle later.

## Interface
- No parameters; all widths are fixed.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- a  in  4  operand A, unsigned.
- b  in  4  operand B, unsigned; ignored by the shift operations.
- op_code  in  3  operation select.
- result  out  5  registered operation result.
- zero_flag  out  1  registered; high exactly when result is 5'b0.

## Operation
All operands are zero-extended to 5 bits before computation. Results wrap modulo 32.
- 000 ADD: {1'b0,a} + {1'b0,b}. Bit 4 is the carry out.
- 001 SUB: {1'b0,a} - {1'b0,b}, two's complement. If a < b, bit 4 is 1 (borrow) and the value is the 5-bit wrap.
- 010 AND: {1'b0, a & b}.
- 011 OR: {1'b0, a | b}.
- 100 XOR: {1'b0, a ^ b}.
- 101 SHL: {a, 1'b0}. The bit shifted out of a[3] lands in result[4].
- 110 SHR: {2'b0, a[3:1]}. Logical shift; a[0] is discarded.
- 111 reserved: result = 5'b0, so zero_flag = 1.
- zero_flag is derived from the next-state result and registered in the same cycle as result. It is never stale relative to result.

## Timing
- Latency is 1 cycle. Inputs sampled at rising edge N appear on result/zero_flag after edge N, and stay stable until after edge N+1.
- Throughput is one operation per cycle. There is no handshake; the unit has no valid or ready signals.
- Reset: when rst_n = 0 at a rising edge, result is set to 5'b0 and zero_flag to 1. Reset takes priority over any op_code or operand.
- Inputs present during reset are discarded. The first valid result is the operation sampled at the first edge with rst_n = 1.
- Asserting reset mid-stream clears the outputs at that edge. No in-flight state survives, because there is only the single output register.
- Outputs never go X after the first reset edge. Before the first edge they are undefined.

## Structure
- Shared package alu_4bit_pkg holds:
  - opcode localparams: OP_ADD=3'd0, OP_SUB=3'd1, OP_AND=3'd2, OP_OR=3'd3, OP_XOR=3'd4, OP_SHL=3'd5, OP_SHR=3'd6, OP_RSV=3'd7;
  - width constants: DATA_W=4, RES_W=5.
- One sub-module is natural: alu_4bit_core, a purely combinational unit that maps (a, b, op_code) to (next_result, next_zero). The top level, alu_4bit, holds only the reset-controlled output register.
- The case statement in alu_4bit_core is fully specified with a default branch, so no latches are inferred.

## Test plan
- Reset: hold rst_n = 0 for 2 edges with a=5, b=3, op=ADD, then check result = 0 and zero_flag = 1. Release reset, and one edge later result = 8.
- ADD: a=3, b=2 gives 5, zero_flag 0. a=15, b=1 gives 5'b10000 (carry). a=0, b=0 gives 0, zero_flag 1.
- SUB: a=7, b=2 gives 5. a=2, b=2 gives 0, zero_flag 1. a=2, b=7 gives 5'b11011 (27, borrow).
- Logic ops:
  - AND: a=12, b=10 gives 8.
  - OR: a=12, b=3 gives 15.
  - XOR: a=10, b=3 gives 9.
  - XOR: a=5, b=5 gives 0, zero_flag 1.
- Shifts:
  - SHL: a=5 gives 10; a=8 gives 16.
  - SHR: a=8 gives 4; a=1 gives 0, zero_flag 1.
  - b is varied during shifts with no effect on result.
- Back-to-back and reserved:
  - Change op_code every cycle through all 8 codes. Each result must appear exactly one edge after its inputs; op 111 gives 0, zero_flag 1.
  - Assert reset mid-sequence; outputs must clear at that edge.
